// File: rtl/instr_sequencer_pkg.sv
// Shared opcode, ALU and state encodings for the instruction sequencer,
// plus helpers that slice the fields out of an 8-bit instruction word.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IMM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       is_alu;
        logic       is_ldi;
        logic       is_hlt;
        logic       is_illegal;
    } dec_t;

    function automatic logic [3:0] ir_opcode(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [7:0] ir);
        return ir[3:2];
    endfunction

    function automatic logic [1:0] ir_rb(input logic [7:0] ir);
        return ir[1:0];
    endfunction

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational opcode decoder: classifies the opcode and picks the ALU operation.
// MOV is an ALU instruction that passes operand B through.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin dec.alu_op = ALU_ADD;    dec.is_alu = 1'b1; end
            OP_SUB: begin dec.alu_op = ALU_SUB;    dec.is_alu = 1'b1; end
            OP_AND: begin dec.alu_op = ALU_AND;    dec.is_alu = 1'b1; end
            OP_OR:  begin dec.alu_op = ALU_OR;     dec.is_alu = 1'b1; end
            OP_XOR: begin dec.alu_op = ALU_XOR;    dec.is_alu = 1'b1; end
            OP_MOV: begin dec.alu_op = ALU_PASS_B; dec.is_alu = 1'b1; end
            OP_LDI: dec.is_ldi = 1'b1;
            OP_HLT: dec.is_hlt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving a 4x8 register file from a req/ack byte port.
// Zero-wait latency: ALU/MOV 4 cycles, LDI 5, NOP 2; a raised request holds until acked.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [1:0] rf_read_addr_a,
    output logic [1:0] rf_read_addr_b,
    output logic [1:0] rf_write_addr,
    output logic       rf_write_en,
    output logic       rf_wsel_imm,
    output logic [2:0] alu_op,
    output logic [7:0] imm_out,
    output logic       halted,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] imm_q, imm_d;
    logic       pending_q, pending_d;
    logic [1:0] rd_addr_a_q, rd_addr_a_d;
    logic [1:0] rd_addr_b_q, rd_addr_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       illegal_q, illegal_d;

    logic [3:0] opcode;
    dec_t       dec;
    logic       req_c;
    logic       ack_c;

    assign opcode = ir_opcode(ir_q);

    instr_decoder u_decoder (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            imm_q       <= 8'h00;
            pending_q   <= 1'b0;
            rd_addr_a_q <= 2'd0;
            rd_addr_b_q <= 2'd0;
            alu_op_q    <= 3'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imm_q       <= imm_d;
            pending_q   <= pending_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            alu_op_q    <= alu_op_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (ack_c) state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec.is_illegal)  state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                else if (dec.is_hlt) state_d = ST_HALT;
                else if (dec.is_ldi) state_d = ST_IMM;
                else if (dec.is_alu) state_d = ST_EXEC;
                else                 state_d = ST_FETCH;
            end
            ST_IMM:  if (ack_c) state_d = ST_WB;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // The immediate request is launched from pending_q, so IMM always spends
    // one cycle arming the request before it can be acknowledged.
    always_comb begin
        req_c       = 1'b0;
        rf_write_en = 1'b0;
        rf_wsel_imm = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH: req_c = run | pending_q;
            ST_IMM:   req_c = pending_q;
            ST_WB: begin
                rf_write_en = 1'b1;
                rf_wsel_imm = (opcode == OP_LDI);
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign ack_c = imem_ack & req_c;

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        pending_d   = pending_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        alu_op_d    = alu_op_q;
        illegal_d   = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (ack_c) begin
                    ir_d      = imem_data;
                    pc_d      = pc_q + 8'd1;
                    pending_d = 1'b0;
                end else if (req_c) begin
                    pending_d = 1'b1;
                end
            end
            ST_DECODE: begin
                rd_addr_a_d = ir_rd(ir_q);
                rd_addr_b_d = ir_rb(ir_q);
                if (dec.is_alu)     alu_op_d  = dec.alu_op;
                if (dec.is_illegal) illegal_d = 1'b1;
            end
            ST_IMM: begin
                if (ack_c) begin
                    imm_d     = imem_data;
                    pc_d      = pc_q + 8'd1;
                    pending_d = 1'b0;
                end else begin
                    pending_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gate with rst_n so the request drops the instant reset asserts.
    assign imem_req       = req_c & rst_n;
    assign imem_addr      = pc_q;
    assign rf_read_addr_a = rd_addr_a_q;
    assign rf_read_addr_b = rd_addr_b_q;
    assign rf_write_addr  = ir_rd(ir_q);
    assign alu_op         = alu_op_q;
    assign imm_out        = imm_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: instruction-level model predicts fetch addresses and register writes,
// a negedge compare process checks every accepted fetch and every write strobe.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, run, spur_ack;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_data;
    logic [1:0] rf_read_addr_a, rf_read_addr_b, rf_write_addr;
    logic       rf_write_en, rf_wsel_imm, halted, illegal;
    logic [2:0] alu_op;
    logic [7:0] imm_out;

    logic       imem_req2, imem_ack2;
    logic [7:0] imem_addr2, imem_data2;
    logic [1:0] ra2, rb2, wa2;
    logic       we2, ws2, halted2, illegal2;
    logic [2:0] alu2;
    logic [7:0] imm2;

    logic [7:0] mem [256];
    int ack_delay, wait_cnt, cyc;
    int n_chk, n_pass;

    typedef struct { logic [1:0] rd; logic [1:0] rb; logic wsel; logic [2:0] alu; logic [7:0] imm; } wr_t;
    logic [7:0] exp_fetch [$];
    wr_t        exp_wr [$];
    int         ack_log [$];
    logic [7:0] ack_addr_log [$];
    int         wr_log [$];
    wr_t        wr_cap [$];
    int         last_req_cyc, halt_cyc, ill_cyc, req2_cnt;

    assign imem_ack   = (imem_req && (wait_cnt >= ack_delay)) || spur_ack;
    assign imem_data  = mem[imem_addr];
    assign imem_ack2  = imem_req2;
    assign imem_data2 = 8'h9C;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            cyc      <= 0;
        end else begin
            cyc      <= cyc + 1;
            wait_cnt <= (!imem_req || imem_ack) ? 0 : wait_cnt + 1;
        end
    end

    instr_sequencer #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .rf_write_addr(rf_write_addr), .rf_write_en(rf_write_en), .rf_wsel_imm(rf_wsel_imm),
        .alu_op(alu_op), .imm_out(imm_out), .halted(halted), .illegal(illegal)
    );

    instr_sequencer #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b1)) dut_hlt (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
        .rf_read_addr_a(ra2), .rf_read_addr_b(rb2),
        .rf_write_addr(wa2), .rf_write_en(we2), .rf_wsel_imm(ws2),
        .alu_op(alu2), .imm_out(imm2), .halted(halted2), .illegal(illegal2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Instruction-level model: walks the program image and lists the fetch
    // addresses and register writes the sequencer must produce.
    task automatic model_run(input logic [7:0] start, input int n_instr);
        logic [7:0] pc, ins, imm;
        logic [3:0] op;
        logic [2:0] alu;
        wr_t w;
        pc = start; imm = 8'h00; alu = 3'd0;
        for (int i = 0; i < n_instr; i++) begin
            ins = mem[pc];
            op  = ins[7:4];
            exp_fetch.push_back(pc);
            pc = pc + 8'd1;
            if (op >= 4'h1 && op <= 4'h6) begin
                alu = (op == 4'h6) ? 3'd5 : 3'(op - 4'h1);
                w = '{ins[3:2], ins[1:0], 1'b0, alu, imm};
                exp_wr.push_back(w);
            end else if (op == 4'h7) begin
                exp_fetch.push_back(pc);
                imm = mem[pc];
                pc  = pc + 8'd1;
                w = '{ins[3:2], ins[1:0], 1'b1, alu, imm};
                exp_wr.push_back(w);
            end else if (op == 4'hF) begin
                break;
            end
        end
    endtask

    initial begin
        wr_t e, got;
        logic [7:0] ea;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_req_cyc = 0; halt_cyc = 0; ill_cyc = 0; req2_cnt = 0;
            end else begin
                if (imem_req) last_req_cyc = cyc + 1;
                if (imem_req2) req2_cnt++;
                if (halted && halt_cyc == 0) halt_cyc = cyc + 1;
                if (illegal && ill_cyc == 0) ill_cyc = cyc + 1;
                if (imem_req && imem_ack) begin
                    ack_log.push_back(cyc + 1);
                    ack_addr_log.push_back(imem_addr);
                    if (exp_fetch.size() == 0) begin
                        n_chk++;
                        $display("FAIL fetch_extra: got fetch at %0h, expected none", imem_addr);
                    end else begin
                        ea = exp_fetch.pop_front();
                        chk("fetch_addr", 32'(imem_addr), 32'(ea));
                    end
                end
                if (rf_write_en) begin
                    got = '{rf_write_addr, rf_read_addr_b, rf_wsel_imm, alu_op, imm_out};
                    wr_log.push_back(cyc + 1);
                    wr_cap.push_back(got);
                    if (exp_wr.size() == 0) begin
                        n_chk++;
                        $display("FAIL write_extra: got write to r%0d, expected none", rf_write_addr);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(rf_write_addr), 32'(e.rd));
                        chk("wr_rd_a", 32'(rf_read_addr_a), 32'(e.rd));
                        chk("wr_rd_b", 32'(rf_read_addr_b), 32'(e.rb));
                        chk("wr_wsel", 32'(rf_wsel_imm), 32'(e.wsel));
                        chk("wr_alu", 32'(alu_op), 32'(e.alu));
                        chk("wr_imm", 32'(imm_out), 32'(e.imm));
                    end
                end
            end
        end
    end

    task automatic enter_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_fetch.delete(); exp_wr.delete();
        ack_log.delete(); ack_addr_log.delete(); wr_log.delete(); wr_cap.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_fetch_left"}, 32'(exp_fetch.size()), 0);
        chk({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
    endtask

    initial begin
        bit found;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; run = 1'b1; spur_ack = 1'b0; ack_delay = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset values with run already high
        idle(2);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_we", 32'(rf_write_en), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_imm", 32'(imm_out), 0);
        chk("rst_alu", 32'(alu_op), 0);
        chk("rst_waddr", 32'(rf_write_addr), 0);

        // Reset asserted while waiting on an immediate fetch
        enter_reset();
        mem[0] = 8'h71; mem[1] = 8'h5A; mem[2] = 8'hF0;
        ack_delay = 3;
        exp_fetch.push_back(8'h00);
        run = 1'b1;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 8'h01) found = 1'b1;
        end
        chk("t1_imm_req_seen", 32'(found), 1);
        chk("t1_first_fetch_done", 32'(exp_fetch.size()), 0);
        rst_n = 1'b0;
        #1;
        chk("t1_req_in_rst", 32'(imem_req), 0);
        chk("t1_we_in_rst", 32'(rf_write_en), 0);
        chk("t1_halted_in_rst", 32'(halted), 0);
        chk("t1_addr_in_rst", 32'(imem_addr), 0);

        // LDI r0,5A ; ADD r1,r2 ; HLT with zero-wait ack
        enter_reset();
        mem[0] = 8'h71; mem[1] = 8'h5A; mem[2] = 8'h16; mem[3] = 8'hF0;
        ack_delay = 0;
        model_run(8'h00, 10);
        release_reset();
        idle(20);
        chk_drained("t2");
        chk("t2_n_fetch", 32'(ack_log.size()), 4);
        chk("t2_first_fetch_cyc", 32'(ack_log[0]), 1);
        chk("t2_first_fetch_addr", 32'(ack_addr_log[0]), 0);
        chk("t2_n_writes", 32'(wr_log.size()), 2);
        chk("t2_ldi_wb_cyc", 32'(wr_log[0]), 5);
        chk("t2_ldi_wsel", 32'(wr_cap[0].wsel), 1);
        chk("t2_ldi_imm", 32'(wr_cap[0].imm), 32'h5A);
        chk("t2_ldi_rd", 32'(wr_cap[0].rd), 0);
        chk("t2_add_wb_cyc", 32'(wr_log[1]), 9);
        chk("t2_add_rd", 32'(wr_cap[1].rd), 1);
        chk("t2_add_alu", 32'(wr_cap[1].alu), 0);
        chk("t2_add_wsel", 32'(wr_cap[1].wsel), 0);
        chk("t2_halt_cyc", 32'(halt_cyc), 12);
        chk("t2_halted", 32'(halted), 1);
        chk("t2_last_req_cyc", 32'(last_req_cyc), 10);

        // Delayed ack with run dropped after the request rose
        enter_reset();
        ack_delay = 3;
        model_run(8'h00, 1);
        run = 1'b1;
        release_reset();
        @(posedge clk); #1;
        run = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("t3_req_hold", 32'(imem_req), 1);
            chk("t3_addr_hold", 32'(imem_addr), 0);
        end
        idle(8);
        chk_drained("t3");
        chk("t3_n_fetch", 32'(ack_log.size()), 1);
        chk("t3_ack_cyc", 32'(ack_log[0]), 4);
        chk("t3_last_req_cyc", 32'(last_req_cyc), 4);

        // 257 NOPs: PC wraps FF -> 00, one fetch every 2 cycles, no writes
        enter_reset();
        ack_delay = 0;
        model_run(8'h00, 257);
        run = 1'b1;
        release_reset();
        for (int i = 0; i < 700 && exp_fetch.size() != 0; i++) @(posedge clk);
        #1;
        run = 1'b0;
        idle(5);
        chk_drained("t4");
        chk("t4_n_fetch", 32'(ack_log.size()), 257);
        if (ack_log.size() == 257) begin
            chk("t4_addr_ff", 32'(ack_addr_log[255]), 32'hFF);
            chk("t4_addr_wrap", 32'(ack_addr_log[256]), 32'h00);
            for (int i = 1; i < 257; i++) chk("t4_nop_spacing", 32'(ack_log[i] - ack_log[i-1]), 2);
        end
        chk("t4_no_writes", 32'(wr_log.size()), 0);

        // Illegal opcode 9C then HLT; the HALT_ON_ILLEGAL=1 instance sees only 9C
        enter_reset();
        mem[0] = 8'h9C; mem[1] = 8'hF0;
        model_run(8'h00, 10);
        run = 1'b1;
        release_reset();
        idle(10);
        chk_drained("t5");
        chk("t5_illegal_sticky", 32'(illegal), 1);
        chk("t5_illegal_cyc", 32'(ill_cyc), 3);
        chk("t5_second_fetch_cyc", 32'(ack_log.size() == 2 ? ack_log[1] : -1), 3);
        chk("t5_halt_cyc", 32'(halt_cyc), 5);
        chk("t5_no_writes", 32'(wr_log.size()), 0);
        chk("t5h_halted", 32'(halted2), 1);
        chk("t5h_illegal", 32'(illegal2), 1);
        chk("t5h_req_cycles", 32'(req2_cnt), 1);
        chk("t5h_no_write", 32'(we2), 0);

        // Spurious ack while the ADD is in EXEC
        enter_reset();
        mem[0] = 8'h16; mem[1] = 8'hF0;
        model_run(8'h00, 10);
        run = 1'b1;
        release_reset();
        @(posedge clk);
        @(posedge clk); #1;
        spur_ack = 1'b1;
        chk("t6_req_exec", 32'(imem_req), 0);
        chk("t6_pc_exec", 32'(imem_addr), 1);
        @(posedge clk); #1;
        spur_ack = 1'b0;
        idle(10);
        chk_drained("t6");
        chk("t6_wb_cyc", 32'(wr_log.size() == 1 ? wr_log[0] : -1), 4);
        chk("t6_next_fetch_cyc", 32'(ack_log.size() == 2 ? ack_log[1] : -1), 5);
        chk("t6_halted", 32'(halted), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
